// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register of the KGP-RISC core.
// Runs loads/stores over a req/ack data-memory port and stalls upstream while an access is outstanding.
module mem_wb_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_valid,
  input  logic [31:0] ex_mem_aluresult,
  input  logic [31:0] ex_mem_storedata,
  input  logic [4:0]  ex_mem_destadd,
  input  logic        ex_mem_regwrite,
  input  logic        ex_mem_memread,
  input  logic        ex_mem_memwrite,
  input  logic        ex_mem_link,
  input  logic [31:0] ex_mem_pcplus4,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        mem_wb_valid,
  output logic        mem_wb_regwrite,
  output logic [4:0]  mem_wb_destadd,
  output logic [31:0] wb_writedata,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [4:0]    lat_destadd;
  logic          lat_regwrite;
  logic          lat_memread;

  logic          access;
  logic          misaligned;
  logic          timeout_hit;
  logic          stall_raw;
  logic          nxt_valid;
  logic          nxt_regwrite;
  logic [4:0]    nxt_destadd;
  logic [31:0]   nxt_data;
  logic          wb_en;

  // memread together with memwrite is treated as a load
  assign access      = ex_mem_valid & (ex_mem_memread | ex_mem_memwrite);
  assign misaligned  = ex_mem_aluresult[1:0] != 2'b00;
  assign timeout_hit = cnt == CW'(TIMEOUT - 1);

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    stall_raw    = 1'b0;
    nxt_valid    = 1'b0;
    nxt_regwrite = 1'b0;
    nxt_destadd  = 5'd0;
    nxt_data     = 32'd0;
    case (state)
      IDLE: begin
        stall_raw = access & ~misaligned;
        if (ex_mem_valid && !access) begin
          nxt_valid    = 1'b1;
          nxt_regwrite = ex_mem_regwrite;
          nxt_destadd  = ex_mem_destadd;
          nxt_data     = ex_mem_link ? ex_mem_pcplus4 : ex_mem_aluresult;
        end
      end
      ACCESS: begin
        stall_raw = ~dmem_ack & ~timeout_hit;
        if (dmem_ack) begin
          nxt_valid    = 1'b1;
          nxt_regwrite = lat_regwrite;
          nxt_destadd  = lat_destadd;
          nxt_data     = lat_memread ? dmem_rdata : dmem_addr;
        end
      end
      default: stall_raw = 1'b0;
    endcase
  end

  // Held low during reset so upstream never sees a stall from a pipeline that is being cleared.
  assign mem_stall = rst & stall_raw;
  assign wb_en     = nxt_regwrite & (nxt_destadd != 5'd0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= '0;
      lat_destadd     <= 5'd0;
      lat_regwrite    <= 1'b0;
      lat_memread     <= 1'b0;
      dmem_req        <= 1'b0;
      dmem_we         <= 1'b0;
      dmem_addr       <= 32'd0;
      dmem_wdata      <= 32'd0;
      mem_wb_valid    <= 1'b0;
      mem_wb_regwrite <= 1'b0;
      mem_wb_destadd  <= 5'd0;
      wb_writedata    <= 32'd0;
      misalign_err    <= 1'b0;
      bus_err         <= 1'b0;
    end else begin
      // Bubbles and stores carry an all-zero triple so WB forwarding never sees a stale value.
      mem_wb_valid    <= nxt_valid;
      mem_wb_regwrite <= wb_en;
      mem_wb_destadd  <= wb_en ? nxt_destadd : 5'd0;
      wb_writedata    <= wb_en ? nxt_data : 32'd0;
      misalign_err    <= 1'b0;
      bus_err         <= 1'b0;
      case (state)
        IDLE: begin
          if (access && misaligned) begin
            misalign_err <= 1'b1;
          end else if (access) begin
            state        <= ACCESS;
            cnt          <= '0;
            dmem_req     <= 1'b1;
            dmem_we      <= ex_mem_memwrite & ~ex_mem_memread;
            dmem_addr    <= ex_mem_aluresult;
            dmem_wdata   <= ex_mem_storedata;
            lat_destadd  <= ex_mem_destadd;
            lat_regwrite <= ex_mem_regwrite & ex_mem_memread;
            lat_memread  <= ex_mem_memread;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            state    <= IDLE;
            dmem_req <= 1'b0;
          end else if (timeout_hit) begin
            state    <= IDLE;
            dmem_req <= 1'b0;
            bus_err  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed instructions push expected write-backs,
// a negedge monitor pops and compares every valid MEM/WB output and checks bubbles are clean.
module tb_mem_wb_stage;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_valid;
  logic [31:0] ex_mem_aluresult;
  logic [31:0] ex_mem_storedata;
  logic [4:0]  ex_mem_destadd;
  logic        ex_mem_regwrite;
  logic        ex_mem_memread;
  logic        ex_mem_memwrite;
  logic        ex_mem_link;
  logic [31:0] ex_mem_pcplus4;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic        mem_wb_valid;
  logic        mem_wb_regwrite;
  logic [4:0]  mem_wb_destadd;
  logic [31:0] wb_writedata;
  logic        misalign_err;
  logic        bus_err;

  mem_wb_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ex_mem_valid(ex_mem_valid), .ex_mem_aluresult(ex_mem_aluresult),
    .ex_mem_storedata(ex_mem_storedata), .ex_mem_destadd(ex_mem_destadd),
    .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_memread(ex_mem_memread),
    .ex_mem_memwrite(ex_mem_memwrite), .ex_mem_link(ex_mem_link),
    .ex_mem_pcplus4(ex_mem_pcplus4),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .mem_wb_valid(mem_wb_valid),
    .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_destadd(mem_wb_destadd),
    .wb_writedata(wb_writedata), .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic [4:0]  dest;
    logic [31:0] data;
  } wb_t;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sdata;
    logic [4:0]  dest;
    logic        rw, mr, mw, link;
    logic [31:0] pc4;
  } instr_t;

  wb_t exp_q[$];
  int  checks  = 0;
  int  errors  = 0;
  int  mis_cnt = 0;
  int  bus_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [127:0] all_outputs();
    return {20'd0, dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_stall, mem_wb_valid,
            mem_wb_regwrite, mem_wb_destadd, wb_writedata, misalign_err, bus_err};
  endfunction

  function automatic instr_t mk(input logic [31:0] alu, input logic [31:0] sdata,
                                input logic [4:0] dest, input logic rw, input logic mr,
                                input logic mw, input logic link, input logic [31:0] pc4);
    instr_t i;
    i.alu = alu; i.sdata = sdata; i.dest = dest; i.rw = rw;
    i.mr = mr; i.mw = mw; i.link = link; i.pc4 = pc4;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    ex_mem_valid     = 1'b1;
    ex_mem_aluresult = i.alu;
    ex_mem_storedata = i.sdata;
    ex_mem_destadd   = i.dest;
    ex_mem_regwrite  = i.rw;
    ex_mem_memread   = i.mr;
    ex_mem_memwrite  = i.mw;
    ex_mem_link      = i.link;
    ex_mem_pcplus4   = i.pc4;
  endtask

  // Monitor: pops one expectation per valid write-back; bubbles must carry an all-zero triple.
  always @(negedge clk) begin
    wb_t e;
    if (rst) begin
      if (misalign_err) mis_cnt++;
      if (bus_err) bus_cnt++;
      if (mem_wb_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wb: got 0x%0h expected no write-back",
                   {mem_wb_regwrite, mem_wb_destadd, wb_writedata});
        end else begin
          e = exp_q.pop_front();
          check("wb_triple", {mem_wb_regwrite, mem_wb_destadd, wb_writedata}, e);
        end
      end else begin
        check("bubble", {mem_wb_regwrite, mem_wb_destadd, wb_writedata}, 0);
      end
    end
  end

  // Presents one instruction, acks on the ack_k-th ACCESS cycle (0 = never), then idles one cycle.
  task automatic run(input string name, input instr_t ins, input int ack_k,
                     input logic [31:0] rdata, input logic exp_we, input int exp_n,
                     input int exp_stall, input logic exp_push, input wb_t exp_wb,
                     input int exp_mis, input int exp_bus);
    int   n, stalls, reqs, bad, mis0, bus0;
    logic stalled, first_req;
    n = 0; stalls = 0; reqs = 0; bad = 0; first_req = 1'b0;
    mis0 = mis_cnt; bus0 = bus_cnt;
    if (exp_push) exp_q.push_back(exp_wb);
    do begin
      @(negedge clk);
      n++;
      if (n == 1) drive(ins);
      dmem_ack   = (ack_k > 0) && (n - 1 == ack_k);
      dmem_rdata = rdata;
      #1;
      if (n == 1) first_req = dmem_req;
      if (dmem_req) begin
        reqs++;
        if (dmem_addr !== ins.alu || dmem_we !== exp_we || (exp_we && dmem_wdata !== ins.sdata))
          bad++;
      end
      stalled = mem_stall;
      if (stalled) stalls++;
    end while (stalled && n < 40);
    @(negedge clk);
    ex_mem_valid = 1'b0;
    dmem_ack     = 1'b0;
    #2;
    check({name, "_latency"}, n, exp_n);
    check({name, "_stall_cycles"}, stalls, exp_stall);
    check({name, "_req_cycles"}, reqs, (exp_n > 1) ? exp_n - 1 : 0);
    check({name, "_req_late_start"}, first_req, 0);
    check({name, "_bus_fields"}, bad, 0);
    check({name, "_misalign"}, mis_cnt - mis0, exp_mis);
    check({name, "_bus_err"}, bus_cnt - bus0, exp_bus);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    ex_mem_valid = 1'b0; ex_mem_aluresult = 32'd0; ex_mem_storedata = 32'd0;
    ex_mem_destadd = 5'd0; ex_mem_regwrite = 1'b0; ex_mem_memread = 1'b0;
    ex_mem_memwrite = 1'b0; ex_mem_link = 1'b0; ex_mem_pcplus4 = 32'd0;

    // Reset held with random inputs: everything must stay at zero.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ex_mem_valid = 1'($urandom); ex_mem_aluresult = $urandom; ex_mem_storedata = $urandom;
      ex_mem_destadd = 5'($urandom); ex_mem_regwrite = 1'($urandom);
      ex_mem_memread = 1'($urandom); ex_mem_memwrite = 1'($urandom);
      ex_mem_link = 1'($urandom); ex_mem_pcplus4 = $urandom;
      dmem_ack = 1'($urandom); dmem_rdata = $urandom;
      #1;
      check("reset_outputs", all_outputs(), 0);
    end
    @(negedge clk);
    ex_mem_valid = 1'b0; dmem_ack = 1'b0;
    rst = 1'b1;

    //  name         instruction                                                 ack rdata         we n  st push {rw,dest,data}                  mis bus
    run("add",       mk(32'h1234, 0, 5'd5, 1, 0, 0, 0, 32'h8),                   0, 0,            0, 1, 0, 1, {1'b1, 5'd5, 32'h0000_1234}, 0, 0);
    run("load_k3",   mk(32'h100, 0, 5'd7, 1, 1, 0, 0, 32'hC),                    3, 32'hDEADBEEF, 0, 4, 3, 1, {1'b1, 5'd7, 32'hDEAD_BEEF}, 0, 0);
    run("store",     mk(32'h104, 32'hCAFEF00D, 5'd0, 0, 0, 1, 0, 32'h10),        1, 32'h1111,     1, 2, 1, 1, {1'b0, 5'd0, 32'h0},         0, 0);
    run("lw_misal",  mk(32'h102, 0, 5'd8, 1, 1, 0, 0, 32'h14),                   0, 0,            0, 1, 0, 0, {1'b0, 5'd0, 32'h0},         1, 0);
    run("jal",       mk(32'h999, 0, 5'd31, 1, 0, 0, 1, 32'h40),                  0, 0,            0, 1, 0, 1, {1'b1, 5'd31, 32'h0000_0040}, 0, 0);
    run("add_r0",    mk(32'h77, 0, 5'd0, 1, 0, 0, 0, 32'h44),                    0, 0,            0, 1, 0, 1, {1'b0, 5'd0, 32'h0},         0, 0);
    run("timeout",   mk(32'h200, 0, 5'd2, 1, 1, 0, 0, 32'h48),                   0, 32'h2222,     0, 5, 4, 0, {1'b0, 5'd0, 32'h0},         0, 1);
    run("ack_at_to", mk(32'h204, 0, 5'd3, 1, 1, 0, 0, 32'h4C),                   4, 32'h0000_55AA, 0, 5, 4, 1, {1'b1, 5'd3, 32'h0000_55AA}, 0, 0);
    run("rd_and_wr", mk(32'h208, 32'hFFFF, 5'd4, 1, 1, 1, 0, 32'h50),            1, 32'h0BAD_F00D, 0, 2, 1, 1, {1'b1, 5'd4, 32'h0BAD_F00D}, 0, 0);
    run("load_b2b",  mk(32'h20C, 0, 5'd6, 1, 1, 0, 0, 32'h54),                   2, 32'h1357_9BDF, 0, 3, 2, 1, {1'b1, 5'd6, 32'h1357_9BDF}, 0, 0);

    // Reset in the 2nd ACCESS cycle: request drops at once, the load is discarded.
    @(negedge clk);
    drive(mk(32'h300, 0, 5'd9, 1, 1, 0, 0, 32'h58));
    @(negedge clk);
    @(negedge clk);
    #2;
    check("req_before_rst", dmem_req, 1);
    rst = 1'b0;
    #1;
    check("req_async_drop", dmem_req, 0);
    check("rst_mid_outputs", all_outputs(), 0);
    @(negedge clk);
    ex_mem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run("post_rst",  mk(32'hABCD, 0, 5'd10, 1, 0, 0, 0, 32'h5C),                 0, 0,            0, 1, 0, 1, {1'b1, 5'd10, 32'h0000_ABCD}, 0, 0);

    @(negedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register of the pipelined KGP-RISC core. Takes the instruction held in EX/MEM, performs any load/store over a req/ack data-memory handshake, and registers the write-back triple (mem_wb_regwrite, mem_wb_destadd, wb_writedata). The register file and the write-back forwarding logic in the decode stage consume that triple. While a memory access is outstanding it stalls all upstream stages and inserts bubbles into WB.

## Interface
- TIMEOUT, 16: maximum ACCESS cycles without dmem_ack before the access is aborted (≥2).
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- ex_mem_valid  input  1  EX/MEM holds a real instruction.
- ex_mem_aluresult  input  32  ALU result / effective address.
- ex_mem_storedata  input  32  rt data for sw.
- ex_mem_destadd  input  5  destination register.
- ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite, ex_mem_link  input  1 each  control bits; link selects PC+4 write-back.
- ex_mem_pcplus4  input  32  PC+4 of the instruction.
- dmem_req  output  1  memory request (registered).
- dmem_we  output  1  1 = store.
- dmem_addr, dmem_wdata  output  32 each  held stable while dmem_req=1.
- dmem_ack  input  1  single-cycle completion strobe.
- dmem_rdata  input  32  load data, valid when dmem_ack=1.
- mem_stall  output  1  combinational; upstream stages hold when 1.
- mem_wb_valid, mem_wb_regwrite  output  1 each  registered.
- mem_wb_destadd  output  5  registered.
- wb_writedata  output  32  registered.
- misalign_err, bus_err  output  1 each  one-cycle registered pulses.

## Operation
- FSM states: IDLE, ACCESS. Reset → IDLE; every output and internal register 0.
- "Access" = ex_mem_valid & (memread | memwrite). memread and memwrite both set is treated as a load.
- IDLE, no access: MEM/WB loads the instruction at the next edge; mem_stall=0.
- IDLE, access, ex_mem_aluresult[1:0]≠0: no request issued; MEM/WB loads a bubble; misalign_err=1 next cycle; mem_stall=0.
- IDLE, aligned access: mem_stall=1. Latch addr, wdata, we, destadd, regwrite and memread. Go to ACCESS; MEM/WB loads a bubble.
- ACCESS: dmem_req=1. The timeout counter increments each cycle from 0.
  - dmem_ack=1: mem_stall=0. MEM/WB loads the latched instruction (load data = dmem_rdata). Clear dmem_req. Go to IDLE.
  - No ack, counter=TIMEOUT-1: abort. mem_stall=0, MEM/WB loads a bubble, bus_err pulses, dmem_req clears, go to IDLE.
  - Ack in the same cycle as the timeout: ack wins and no bus_err.
  - Otherwise mem_stall=1 and MEM/WB loads a bubble.
- Write-back select: link → pcplus4; else memread → load data; else aluresult.
- mem_wb_regwrite = valid & regwrite & (destadd≠0). Stores and bubbles give regwrite=0, writedata=0, destadd=0.
- Asynchronous reset mid-access drops dmem_req immediately and discards the access. The memory side must tolerate an abandoned request.

## Timing
- Non-memory instruction: 1 cycle in MEM; appears on the MEM/WB outputs the edge after it is presented.
- Load/store with ack in the k-th ACCESS cycle (k≥1): k+1 cycles in MEM; mem_stall high for k cycles.
- dmem_req rises 1 cycle after the instruction is presented. Address and data stay constant until the ack/abort edge.
- Back-to-back accesses: after an ack edge, the next instruction's IDLE evaluation happens in the following cycle, giving at least one idle cycle on dmem_req between requests.
- Bubbles during a stall never repeat the previous write-back: every stall cycle clears mem_wb_regwrite.

## Test plan
- Reset: hold rst=0 with random inputs → all outputs 0. Release, then present an add with alu=0x1234, dest=5 → next edge: regwrite=1, destadd=5, writedata=0x1234.
- Load at addr 0x100, ack on the 3rd ACCESS cycle with rdata=0xDEADBEEF → mem_stall high for 3 cycles, dmem_req high for cycles 2–4, then regwrite=1, writedata=0xDEADBEEF. The preceding stall cycles carry bubbles.
- Store at 0x104, data 0xCAFEF00D, immediate ack → dmem_we=1, dmem_wdata=0xCAFEF00D, mem_wb_regwrite=0, total MEM latency 2 cycles.
- lw at 0x102 → no dmem_req, misalign_err pulses once, bubble written. jal with link, pcplus4=0x40, dest=31 → writedata=0x40. Add with dest=0 → regwrite=0.
- TIMEOUT=4, ack never arrives → bus_err pulses after the 4th ACCESS cycle and the pipeline resumes. Repeat with ack in exactly the 4th cycle → load completes with no bus_err.
- Assert rst in the 2nd ACCESS cycle → dmem_req falls asynchronously and the FSM is in IDLE after release.
